// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state enums and immediate field positions for the execute unit
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_SUB  = 3'd2,
        OP_NAND = 3'd3,
        OP_BNE  = 3'd4,
        OP_LW   = 3'd5,
        OP_SW   = 3'd6,
        OP_J    = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } exec_state_e;

    localparam int ADDI_SIGN_BIT = 6;
    localparam int ADDI_MAG_MSB  = 5;
    localparam int BNE_SIGN_BIT  = 12;
    localparam int BNE_HI_MSB    = 11;
    localparam int BNE_HI_LSB    = 10;
    localparam int BNE_LO_MSB    = 3;
    localparam int OFF7_MSB      = 6;
    localparam int SW_HI_MSB     = 12;
    localparam int SW_HI_LSB     = 10;
    localparam int SW_LO_MSB     = 3;

endpackage

// File: rtl/alu_arith.sv
// rtl/alu_arith.sv - combinational ALU datapath and LW/SW effective address generation
module alu_arith
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [15:0]       ir,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] addr
);

    logic [DATA_W-1:0] mag_addi;
    logic [DATA_W-1:0] mag_bne;
    logic [DATA_W-1:0] off_lw;
    logic [DATA_W-1:0] off_sw;
    logic              unused_ir;

    assign mag_addi  = DATA_W'(reg2[ADDI_MAG_MSB:0]);
    assign mag_bne   = DATA_W'({reg2[BNE_HI_MSB:BNE_HI_LSB], reg2[BNE_LO_MSB:0]});
    assign off_lw    = DATA_W'(reg2[OFF7_MSB:0]);
    assign off_sw    = DATA_W'({ir[SW_HI_MSB:SW_HI_LSB], ir[SW_LO_MSB:0]});
    assign unused_ir = ^{ir[15:13], ir[9:4]};

    // For LW/SW the result carries the effective address rather than writeback data
    always_comb begin
        result = '0;
        case (alu_op_e'(alu_sel))
            OP_ADD:  result = reg1 + reg2;
            OP_ADDI: result = reg2[ADDI_SIGN_BIT] ? reg1 - mag_addi : reg1 + mag_addi;
            OP_SUB:  result = reg1 - reg2;
            OP_NAND: result = ~(reg1 & reg2);
            OP_BNE:  result = reg2[BNE_SIGN_BIT] ? reg1 - mag_bne : reg1 + mag_bne;
            OP_LW:   result = reg1 + off_lw;
            OP_SW:   result = reg1 + off_sw;
            OP_J:    result = reg1 + off_lw;
            default: result = '0;
        endcase
    end

    assign addr = result[ADDR_W-1:0];

endmodule

// File: rtl/alu_apb_exec.sv
// rtl/alu_apb_exec.sv - execute unit with issue handshake, APB master for LW/SW and wait-state timeout
module alu_apb_exec
    import alu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [15:0]       ir,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYC - 1);

    exec_state_e       state, state_nx;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx;
    logic              psel_nx, penable_nx, pwrite_nx;
    logic [ADDR_W-1:0] paddr_nx;
    logic [DATA_W-1:0] pwdata_nx;
    logic              res_valid_nx, res_err_nx;
    logic [DATA_W-1:0] res_data_nx;
    logic [DATA_W-1:0] arith_result;
    logic [ADDR_W-1:0] arith_addr;
    alu_op_e           op;

    alu_arith #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_arith (
        .alu_sel (alu_sel),
        .reg1    (reg1),
        .reg2    (reg2),
        .ir      (ir),
        .result  (arith_result),
        .addr    (arith_addr)
    );

    assign op       = alu_op_e'(alu_sel);
    assign op_ready = (state == ST_IDLE);

    always_comb begin
        state_nx     = state;
        wait_cnt_nx  = wait_cnt;
        psel_nx      = psel;
        penable_nx   = penable;
        pwrite_nx    = pwrite;
        paddr_nx     = paddr;
        pwdata_nx    = pwdata;
        res_valid_nx = 1'b0;
        res_err_nx   = 1'b0;
        res_data_nx  = res_data;
        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    if (op == OP_LW || op == OP_SW) begin
                        state_nx    = ST_SETUP;
                        wait_cnt_nx = '0;
                        psel_nx     = 1'b1;
                        pwrite_nx   = (op == OP_SW);
                        paddr_nx    = arith_addr;
                        pwdata_nx   = (op == OP_SW) ? reg2 : '0;
                    end else begin
                        res_valid_nx = 1'b1;
                        res_data_nx  = arith_result;
                    end
                end
            end
            ST_SETUP: begin
                state_nx   = ST_ACCESS;
                penable_nx = 1'b1;
            end
            ST_ACCESS: begin
                if (pready) begin
                    state_nx     = ST_RESP;
                    psel_nx      = 1'b0;
                    penable_nx   = 1'b0;
                    res_valid_nx = 1'b1;
                    res_err_nx   = pslverr;
                    res_data_nx  = pwrite ? '0 : prdata;
                end else if (TIMEOUT_CYC > 0 && wait_cnt == LAST_WAIT) begin
                    // Last permitted wait cycle expired without PREADY
                    state_nx     = ST_RESP;
                    psel_nx      = 1'b0;
                    penable_nx   = 1'b0;
                    res_valid_nx = 1'b1;
                    res_err_nx   = 1'b1;
                    res_data_nx  = '0;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            res_data  <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_cnt_nx;
            psel      <= psel_nx;
            penable   <= penable_nx;
            pwrite    <= pwrite_nx;
            paddr     <= paddr_nx;
            pwdata    <= pwdata_nx;
            res_valid <= res_valid_nx;
            res_err   <= res_err_nx;
            res_data  <= res_data_nx;
        end
    end

endmodule

// File: tb/tb_alu_apb_exec.sv
// tb/tb_alu_apb_exec.sv - scoreboard bench with APB slave/memory model and randomized op mix
module tb_alu_apb_exec;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  alu_sel = '0;
    logic [15:0] reg1 = '0, reg2 = '0, ir = '0;
    logic        res_valid, res_err;
    logic [15:0] res_data;
    logic [15:0] paddr, pwdata;
    logic        psel, penable, pwrite;
    logic [15:0] prdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0;

    always #5 clk = ~clk;

    alu_apb_exec #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .alu_sel(alu_sel), .reg1(reg1), .reg2(reg2), .ir(ir),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [0:65535];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && res_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h expected=none", res_data);
            end else begin
                e = sb.pop_front();
                chk("res_data", {16'h0, res_data}, {16'h0, e.data});
                chk("res_err", {31'h0, res_err}, {31'h0, e.err});
            end
        end
    end

    function automatic logic [15:0] ref_alu(input int op, input int a, input int b);
        int r, m;
        m = ((b >> 10) & 3) * 16 + (b & 15);
        case (op)
            0: r = a + b;
            1: r = (b & 'h40) != 0 ? a - (b & 'h3F) : a + (b & 'h3F);
            2: r = a - b;
            3: r = ~(a & b);
            4: r = (b & 'h1000) != 0 ? a - m : a + m;
            7: r = a + (b & 'h7F);
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    task automatic push_exp(input logic [15:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic do_alu(input int op, input logic [15:0] a, input logic [15:0] b, input logic [15:0] irv);
        op_valid = 1'b1; alu_sel = 3'(op); reg1 = a; reg2 = b; ir = irv;
        chk("alu_op_ready", {31'h0, op_ready}, 32'h1);
        push_exp(ref_alu(op, int'(a), int'(b)), 1'b0);
        @(negedge clk);
        chk("alu_res_valid", {31'h0, res_valid}, 32'h1);
    endtask

    task automatic do_mem(input int op, input logic [15:0] a, input logic [15:0] b, input logic [15:0] irv,
                          input int w, input logic err);
        int          addr, ncyc;
        bit          tmo;
        logic [15:0] ed;
        if (op == 5) addr = (int'(a) + (int'(b) & 'h7F)) & 'hFFFF;
        else         addr = (int'(a) + ((int'(irv) >> 10) & 7) * 16 + (int'(irv) & 15)) & 'hFFFF;
        tmo  = (w >= TO);
        ed   = (tmo || op == 6) ? 16'h0 : mem[addr];
        ncyc = tmo ? TO : w + 1;
        op_valid = 1'b1; alu_sel = 3'(op); reg1 = a; reg2 = b; ir = irv;
        chk("mem_op_ready", {31'h0, op_ready}, 32'h1);
        push_exp(ed, tmo || err);
        @(negedge clk);
        op_valid = 1'b0; alu_sel = 3'($urandom); reg1 = 16'($urandom); reg2 = 16'($urandom); ir = 16'($urandom);
        chk("setup_psel", {31'h0, psel}, 32'h1);
        chk("setup_penable", {31'h0, penable}, 32'h0);
        chk("setup_paddr", {16'h0, paddr}, addr);
        chk("setup_pwrite", {31'h0, pwrite}, (op == 6) ? 32'h1 : 32'h0);
        chk("setup_op_ready", {31'h0, op_ready}, 32'h0);
        if (op == 6) chk("setup_pwdata", {16'h0, pwdata}, {16'h0, b});
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            chk("access_psel", {30'h0, psel, penable}, 32'h3);
            chk("access_paddr", {16'h0, paddr}, addr);
            if (op == 6) chk("access_pwdata", {16'h0, pwdata}, {16'h0, b});
            pready  = !tmo && (c == w);
            pslverr = pready ? err : 1'b0;
            prdata  = pready ? mem[paddr] : 16'($urandom);
        end
        @(negedge clk);
        pready = 1'b0; pslverr = 1'b0;
        chk("resp_psel", {30'h0, psel, penable}, 32'h0);
        chk("resp_valid", {31'h0, res_valid}, 32'h1);
        chk("resp_op_ready", {31'h0, op_ready}, 32'h0);
        if (op == 6 && !(tmo || err)) mem[addr] = b;
        @(negedge clk);
        chk("post_op_ready", {31'h0, op_ready}, 32'h1);
        chk("post_res_valid", {31'h0, res_valid}, 32'h0);
    endtask

    task automatic idle(input int n);
        op_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, w;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503 + 7);
        mem[16'h0104] = 16'hBEEF;
        #1;
        chk("rst_outputs", {psel, penable, pwrite, res_valid, res_err}, 32'h0);
        chk("rst_paddr_pwdata", {paddr, pwdata}, 32'h0);
        chk("rst_res_data", {16'h0, res_data}, 32'h0);
        chk("rst_op_ready", {31'h0, op_ready}, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_alu(1, 16'h0010, 16'h0045, 16'h0);
        do_alu(0, 16'hFFFF, 16'h0002, 16'h0);
        idle(1);
        do_mem(5, 16'h0100, 16'h0004, 16'h0, 0, 1'b0);
        do_mem(6, 16'h0200, 16'h1234, 16'h0402, 3, 1'b0);
        do_mem(5, 16'h0200, 16'h0012, 16'h0, 0, 1'b0);
        do_mem(5, 16'h0300, 16'h0001, 16'h0, 10, 1'b0);
        do_mem(6, 16'h0210, 16'h5555, 16'h0003, 0, 1'b1);
        do_mem(5, 16'h0104, 16'h0000, 16'h0, 1, 1'b1);

        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 7);
            if (op == 5 || op == 6) begin
                w = $urandom_range(0, 5);
                do_mem(op, 16'(16'h0100 + $urandom_range(0, 3) * 16), 16'($urandom_range(0, 3) * 16 + $urandom_range(0, 1)),
                       16'($urandom), w, $urandom_range(0, 7) == 0);
            end else begin
                do_alu(op, 16'($urandom), 16'($urandom), 16'($urandom));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        idle(1);

        // Reset pulled during ACCESS: transfer is dropped and no result appears
        op_valid = 1'b1; alu_sel = 3'd5; reg1 = 16'h0300; reg2 = 16'h0; ir = 16'h0;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_access", {30'h0, psel, penable}, 32'h3);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_apb", {30'h0, psel, penable}, 32'h0);
        chk("async_rst_res_valid", {31'h0, res_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_release_op_ready", {31'h0, op_ready}, 32'h1);
        chk("rst_release_psel", {31'h0, psel}, 32'h0);
        idle(4);
        do_alu(2, 16'h0005, 16'h0007, 16'h0);
        idle(3);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
